// File: rtl/scb_warp_if.sv
// IB <-> scoreboard signal bundle for one warp.
// master = instruction buffer side, slave = scoreboard side.
interface scb_warp_if;
  logic [4:0] Src1_IB_Scb;
  logic [4:0] Src2_IB_Scb;
  logic [4:0] Dst_IB_Scb;
  logic       Src1_Valid_IB_Scb;
  logic       Src2_Valid_IB_Scb;
  logic       Dst_Valid_IB_Scb;
  logic       Replayable_IB_Scb;
  logic       RP_Grt_IB_Scb;
  logic       Replay_Complete_IB_Scb;
  logic [1:0] Replay_Complete_ScbID_IB_Scb;
  logic       Clear_Valid_WB_Scb;
  logic [1:0] Clear_ScbID_WB_Scb;
  logic       Full_Scb_IB;
  logic       Empty_Scb_IB;
  logic       Dependent_Scb_IB;
  logic [1:0] ScbID_Scb_IB;

  modport master (
    output Src1_IB_Scb, Src2_IB_Scb, Dst_IB_Scb,
           Src1_Valid_IB_Scb, Src2_Valid_IB_Scb, Dst_Valid_IB_Scb,
           Replayable_IB_Scb, RP_Grt_IB_Scb,
           Replay_Complete_IB_Scb, Replay_Complete_ScbID_IB_Scb,
           Clear_Valid_WB_Scb, Clear_ScbID_WB_Scb,
    input  Full_Scb_IB, Empty_Scb_IB, Dependent_Scb_IB, ScbID_Scb_IB
  );

  modport slave (
    input  Src1_IB_Scb, Src2_IB_Scb, Dst_IB_Scb,
           Src1_Valid_IB_Scb, Src2_Valid_IB_Scb, Dst_Valid_IB_Scb,
           Replayable_IB_Scb, RP_Grt_IB_Scb,
           Replay_Complete_IB_Scb, Replay_Complete_ScbID_IB_Scb,
           Clear_Valid_WB_Scb, Clear_ScbID_WB_Scb,
    output Full_Scb_IB, Empty_Scb_IB, Dependent_Scb_IB, ScbID_Scb_IB
  );
endinterface

// File: rtl/scb_warp.sv
// Per-warp scoreboard: tracks in-flight register writers / replayable memory ops.
// Define SCB_WB_BYPASS_EN to let same-cycle releases drop out of Full/Empty/Dependent.
module scb_warp #(
  parameter int unsigned NUM_ENTRIES = 4
) (
  input logic       clk,
  input logic       rst,
  scb_warp_if.slave ib
);

  localparam int unsigned ID_W = 2;

  logic [NUM_ENTRIES-1:0]      r_valid;
  logic [NUM_ENTRIES-1:0]      r_dstv;
  logic [NUM_ENTRIES-1:0]      r_rep;
  logic [NUM_ENTRIES-1:0]      r_cmp;
  logic [NUM_ENTRIES-1:0][4:0] r_dst;

  logic [NUM_ENTRIES-1:0] w_wb_hit;
  logic [NUM_ENTRIES-1:0] w_rc_hit;
  logic [NUM_ENTRIES-1:0] w_release;
  logic [NUM_ENTRIES-1:0] w_set_cmp;
  logic [NUM_ENTRIES-1:0] w_vis_valid;
  logic [NUM_ENTRIES-1:0] w_raw;
  logic [ID_W-1:0]        w_free_id;
  logic                   w_found;
  logic                   w_alloc;

  // Load entries need both replay completion and writeback before they retire.
  always_comb begin
    w_wb_hit  = '0;
    w_rc_hit  = '0;
    w_release = '0;
    w_set_cmp = '0;
    for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
      w_wb_hit[i]  = r_valid[i] & ib.Clear_Valid_WB_Scb &
                     (ib.Clear_ScbID_WB_Scb == ID_W'(i));
      w_rc_hit[i]  = r_valid[i] & r_rep[i] & ib.Replay_Complete_IB_Scb &
                     (ib.Replay_Complete_ScbID_IB_Scb == ID_W'(i));
      w_release[i] = (~r_rep[i] & w_wb_hit[i]) |
                     (r_rep[i] & ~r_dstv[i] & w_rc_hit[i]) |
                     (r_rep[i] & r_dstv[i] & w_wb_hit[i] & (r_cmp[i] | w_rc_hit[i]));
      w_set_cmp[i] = w_rc_hit[i] & r_dstv[i];
    end
  end

  always_comb begin
    w_free_id = '0;
    w_found   = 1'b0;
    for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
      if (!r_valid[i] && !w_found) begin
        w_free_id = ID_W'(i);
        w_found   = 1'b1;
      end
    end
  end

`ifdef SCB_WB_BYPASS_EN
  assign w_vis_valid = r_valid & ~w_release;
`else
  assign w_vis_valid = r_valid;
`endif

  always_comb begin
    w_raw = '0;
    for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
      w_raw[i] = w_vis_valid[i] & r_dstv[i] &
                 ((ib.Src1_Valid_IB_Scb & (r_dst[i] == ib.Src1_IB_Scb)) |
                  (ib.Src2_Valid_IB_Scb & (r_dst[i] == ib.Src2_IB_Scb)) |
                  (ib.Dst_Valid_IB_Scb  & (r_dst[i] == ib.Dst_IB_Scb)));
    end
  end

  assign w_alloc = ib.RP_Grt_IB_Scb & (ib.Dst_Valid_IB_Scb | ib.Replayable_IB_Scb) & ~(&r_valid);

  assign ib.Full_Scb_IB      = &w_vis_valid;
  assign ib.Empty_Scb_IB     = ~|w_vis_valid;
  assign ib.Dependent_Scb_IB = |w_raw;
  assign ib.ScbID_Scb_IB     = w_free_id;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= '0;
      r_dstv  <= '0;
      r_rep   <= '0;
      r_cmp   <= '0;
      r_dst   <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
        if (w_release[i])      r_valid[i] <= 1'b0;
        else if (w_set_cmp[i]) r_cmp[i]   <= 1'b1;
      end
      if (w_alloc) begin
        r_valid[w_free_id] <= 1'b1;
        r_dst[w_free_id]   <= ib.Dst_IB_Scb;
        r_dstv[w_free_id]  <= ib.Dst_Valid_IB_Scb;
        r_rep[w_free_id]   <= ib.Replayable_IB_Scb;
        r_cmp[w_free_id]   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_scb_warp.sv
// Self-checking bench for scb_warp: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against an entry-list model.
module tb_scb_warp;

  logic clk = 1'b0;
  logic rst = 1'b0;
  bit   cmp_en = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  scb_warp_if bus ();

  scb_warp #(.NUM_ENTRIES(4)) dut (
    .clk (clk),
    .rst (rst),
    .ib  (bus)
  );

`ifdef SCB_WB_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  // Model: list of four slots, each either free or holding an instruction record.
  bit       m_valid [4];
  bit [4:0] m_dst   [4];
  bit       m_dstv  [4];
  bit       m_rep   [4];
  bit       m_cmp   [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic m_clear();
    for (int i = 0; i < 4; i++) begin
      m_valid[i] = 1'b0;
      m_cmp[i]   = 1'b0;
    end
  endtask

  // Does this cycle's clear/replay traffic retire slot i?
  function automatic bit m_retires(input int i);
    bit wb, rc;
    if (!m_valid[i]) return 1'b0;
    wb = bus.Clear_Valid_WB_Scb && (int'(bus.Clear_ScbID_WB_Scb) == i);
    rc = bus.Replay_Complete_IB_Scb && (int'(bus.Replay_Complete_ScbID_IB_Scb) == i);
    if (!m_rep[i])  return wb;             // plain register writer
    if (!m_dstv[i]) return rc;             // store
    return wb && (m_cmp[i] || rc);         // load
  endfunction

  function automatic int m_first_free();
    for (int i = 0; i < 4; i++) if (!m_valid[i]) return i;
    return 0;
  endfunction

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < 4; i++) if (m_valid[i]) c++;
    return c;
  endfunction

  always @(posedge clk) begin
    if (rst === 1'b1) begin
      bit rel [4];
      int fid;
      bit full;
      fid  = m_first_free();
      full = (m_count() == 4);
      for (int i = 0; i < 4; i++) rel[i] = m_retires(i);
      for (int i = 0; i < 4; i++) begin
        if (rel[i]) m_valid[i] = 1'b0;
        else if (m_valid[i] && m_rep[i] && m_dstv[i] && bus.Replay_Complete_IB_Scb &&
                 int'(bus.Replay_Complete_ScbID_IB_Scb) == i)
          m_cmp[i] = 1'b1;
      end
      if (bus.RP_Grt_IB_Scb && (bus.Dst_Valid_IB_Scb || bus.Replayable_IB_Scb) && !full) begin
        m_valid[fid] = 1'b1;
        m_dst[fid]   = bus.Dst_IB_Scb;
        m_dstv[fid]  = bus.Dst_Valid_IB_Scb;
        m_rep[fid]   = bus.Replayable_IB_Scb;
        m_cmp[fid]   = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      int  cnt;
      bit  dep;
      bit  vis;
      cnt = 0;
      dep = 1'b0;
      for (int i = 0; i < 4; i++) begin
        vis = m_valid[i] && !(BYPASS && rst === 1'b1 && m_retires(i));
        if (vis) cnt++;
        if (vis && m_dstv[i] &&
            ((bus.Src1_Valid_IB_Scb && bus.Src1_IB_Scb == m_dst[i]) ||
             (bus.Src2_Valid_IB_Scb && bus.Src2_IB_Scb == m_dst[i]) ||
             (bus.Dst_Valid_IB_Scb  && bus.Dst_IB_Scb  == m_dst[i])))
          dep = 1'b1;
      end
      chk("full",  32'(bus.Full_Scb_IB),      32'(cnt == 4));
      chk("empty", 32'(bus.Empty_Scb_IB),     32'(cnt == 0));
      chk("dep",   32'(bus.Dependent_Scb_IB), 32'(dep));
      chk("scbid", 32'(bus.ScbID_Scb_IB),     32'(m_first_free()));
    end
  end

  task automatic idle();
    bus.Src1_IB_Scb = '0;  bus.Src2_IB_Scb = '0;  bus.Dst_IB_Scb = '0;
    bus.Src1_Valid_IB_Scb = 1'b0; bus.Src2_Valid_IB_Scb = 1'b0; bus.Dst_Valid_IB_Scb = 1'b0;
    bus.Replayable_IB_Scb = 1'b0; bus.RP_Grt_IB_Scb = 1'b0;
    bus.Replay_Complete_IB_Scb = 1'b0; bus.Replay_Complete_ScbID_IB_Scb = '0;
    bus.Clear_Valid_WB_Scb = 1'b0; bus.Clear_ScbID_WB_Scb = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic grant(input logic [4:0] d, input logic dv, input logic rp);
    bus.RP_Grt_IB_Scb = 1'b1; bus.Dst_IB_Scb = d;
    bus.Dst_Valid_IB_Scb = dv; bus.Replayable_IB_Scb = rp;
  endtask

  task automatic wb(input logic [1:0] id);
    bus.Clear_Valid_WB_Scb = 1'b1; bus.Clear_ScbID_WB_Scb = id;
  endtask

  task automatic rc(input logic [1:0] id);
    bus.Replay_Complete_IB_Scb = 1'b1; bus.Replay_Complete_ScbID_IB_Scb = id;
  endtask

  initial begin
    idle();
    m_clear();
    #12;
    cmp_en = 1'b1;
    chk("rst_empty", 32'(bus.Empty_Scb_IB), 1);
    chk("rst_full",  32'(bus.Full_Scb_IB), 0);
    chk("rst_dep",   32'(bus.Dependent_Scb_IB), 0);
    chk("rst_id",    32'(bus.ScbID_Scb_IB), 0);
    step();
    rst = 1'b1;

    // First allocation and RAW against it
    grant(5'd5, 1'b1, 1'b0); #1;
    chk("s1_id", 32'(bus.ScbID_Scb_IB), 0);
    step(); idle();
    bus.Src1_IB_Scb = 5'd5; bus.Src1_Valid_IB_Scb = 1'b1; #1;
    chk("s1_empty", 32'(bus.Empty_Scb_IB), 0);
    chk("s1_dep",   32'(bus.Dependent_Scb_IB), 1);
    idle(); wb(2'd0); step(); idle(); #1;
    chk("s1_freed", 32'(bus.Empty_Scb_IB), 1);

    // Fill all four, free the middle one
    for (int i = 0; i < 4; i++) begin
      idle(); grant(5'(i + 1), 1'b1, 1'b0); #1;
      chk("s2_id", 32'(bus.ScbID_Scb_IB), 32'(i));
      step();
    end
    idle(); #1;
    chk("s2_full",    32'(bus.Full_Scb_IB), 1);
    chk("s2_id_full", 32'(bus.ScbID_Scb_IB), 0);
    wb(2'd2); step(); idle(); #1;
    chk("s2_notfull", 32'(bus.Full_Scb_IB), 0);
    chk("s2_id2",     32'(bus.ScbID_Scb_IB), 2);
    wb(2'd0); step(); idle(); wb(2'd1); step(); idle(); wb(2'd3); step(); idle(); #1;
    chk("s2_empty", 32'(bus.Empty_Scb_IB), 1);

    // Load: WB before replay completion is a partial pass
    grant(5'd7, 1'b1, 1'b1); step(); idle();
    wb(2'd0); step(); idle();
    bus.Src2_IB_Scb = 5'd7; bus.Src2_Valid_IB_Scb = 1'b1; #1;
    chk("s3_held", 32'(bus.Empty_Scb_IB), 0);
    chk("s3_dep",  32'(bus.Dependent_Scb_IB), 1);
    idle(); rc(2'd0); step(); idle(); wb(2'd0); step(); idle(); #1;
    chk("s3_freed", 32'(bus.Empty_Scb_IB), 1);

    // Store in ID 1: no RAW, released by replay completion
    grant(5'd9, 1'b1, 1'b0); step(); idle();
    grant(5'd7, 1'b0, 1'b1); step(); idle();
    wb(2'd0); step(); idle();
    bus.Src1_IB_Scb = 5'd7; bus.Src1_Valid_IB_Scb = 1'b1;
    bus.Src2_IB_Scb = 5'd7; bus.Src2_Valid_IB_Scb = 1'b1; #1;
    chk("s4_dep",   32'(bus.Dependent_Scb_IB), 0);
    chk("s4_empty", 32'(bus.Empty_Scb_IB), 0);
    chk("s4_id",    32'(bus.ScbID_Scb_IB), 0);
    idle(); rc(2'd1); step(); idle(); #1;
    chk("s4_freed", 32'(bus.Empty_Scb_IB), 1);

    // Simultaneous grant and clear
    grant(5'd12, 1'b1, 1'b0); step(); idle();
    grant(5'd13, 1'b1, 1'b0); wb(2'd0);
    bus.Src1_IB_Scb = 5'd12; bus.Src1_Valid_IB_Scb = 1'b1; #1;
    chk("s5_id",  32'(bus.ScbID_Scb_IB), 1);
    chk("s5_dep", 32'(bus.Dependent_Scb_IB), BYPASS ? 0 : 1);
    step(); idle(); #1;
    chk("s5_id0",   32'(bus.ScbID_Scb_IB), 0);
    chk("s5_empty", 32'(bus.Empty_Scb_IB), 0);
    wb(2'd1); step(); idle();

    // Asynchronous reset with three live entries
    grant(5'd20, 1'b1, 1'b0); step(); idle();
    grant(5'd21, 1'b1, 1'b0); step(); idle();
    grant(5'd22, 1'b1, 1'b0); step(); idle();
    bus.Src1_IB_Scb = 5'd20; bus.Src1_Valid_IB_Scb = 1'b1; #1;
    chk("s6_pre_dep", 32'(bus.Dependent_Scb_IB), 1);
    rst = 1'b0; m_clear(); #1;
    chk("s6_empty", 32'(bus.Empty_Scb_IB), 1);
    chk("s6_full",  32'(bus.Full_Scb_IB), 0);
    chk("s6_dep",   32'(bus.Dependent_Scb_IB), 0);
    step(); rst = 1'b1; idle(); wb(2'd1); step(); idle(); #1;
    chk("s6_after", 32'(bus.Empty_Scb_IB), 1);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      idle();
      if ($urandom_range(0, 999) < 3) begin
        rst = 1'b0; m_clear(); step(); rst = 1'b1; continue;
      end
      bus.Src1_IB_Scb = 5'($urandom_range(0, 7));
      bus.Src2_IB_Scb = 5'($urandom_range(0, 7));
      bus.Dst_IB_Scb  = 5'($urandom_range(0, 7));
      bus.Src1_Valid_IB_Scb = 1'($urandom_range(0, 1));
      bus.Src2_Valid_IB_Scb = 1'($urandom_range(0, 1));
      bus.Dst_Valid_IB_Scb  = 1'($urandom_range(0, 1));
      bus.Replayable_IB_Scb = 1'($urandom_range(0, 2) == 0);
      bus.RP_Grt_IB_Scb = ($urandom_range(0, 99) < 45) &&
                          (m_count() < 4 || $urandom_range(0, 99) < 5);
      bus.Clear_Valid_WB_Scb = ($urandom_range(0, 99) < 35);
      bus.Clear_ScbID_WB_Scb = 2'($urandom_range(0, 3));
      bus.Replay_Complete_IB_Scb = ($urandom_range(0, 99) < 30);
      bus.Replay_Complete_ScbID_IB_Scb = 2'($urandom_range(0, 3));
      step();
    end

    idle();
    step();
    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
